// File: rtl/program_loader.sv
// Byte-stream program loader: packs little-endian words into instruction
// memory, then hands the memory port to the core and launches it.
module program_loader #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [AW-1:0] mem_lo,
    output logic [31:0]   mem_in,
    output logic          mem_en,
    output logic          mem_sel,
    output logic          start,
    input  logic          core_done,
    output logic          busy,
    output logic [AW:0]   word_count,
    output logic          err
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_WRITE,
        S_LAUNCH,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    state_t        state_q;
    logic [1:0]    idx_q;
    logic [31:0]   word_q;
    logic [AW-1:0] addr_q;
    logic          last_q;

    logic [AW-1:0] mem_lo_q;
    logic [31:0]   mem_in_q;
    logic          mem_en_q;
    logic          mem_sel_q;
    logic          start_q;
    logic          busy_q;
    logic [AW:0]   cnt_q;
    logic          err_q;

    logic          xfer;
    logic [31:0]   word_d;

    assign in_ready   = (state_q == S_LOAD);
    assign xfer       = in_valid & in_ready;

    assign mem_lo     = mem_lo_q;
    assign mem_in     = mem_in_q;
    assign mem_en     = mem_en_q;
    assign mem_sel    = mem_sel_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign word_count = cnt_q;
    assign err        = err_q;

    // Word with the incoming byte merged at the current lane
    always_comb begin
        word_d = word_q;
        word_d[{idx_q, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_LOAD;
            idx_q     <= 2'd0;
            word_q    <= 32'd0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            mem_lo_q  <= '0;
            mem_in_q  <= 32'd0;
            mem_en_q  <= 1'b0;
            mem_sel_q <= 1'b1;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (xfer) begin
                        if (idx_q == 2'd3 || in_last) begin
                            state_q  <= S_WRITE;
                            last_q   <= in_last;
                            mem_en_q <= 1'b1;
                            mem_lo_q <= addr_q;
                            mem_in_q <= word_d;
                            word_q   <= 32'd0;
                            idx_q    <= 2'd0;
                        end else begin
                            word_q <= word_d;
                            idx_q  <= idx_q + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    mem_en_q <= 1'b0;
                    addr_q   <= addr_q + AW'(1);
                    if (cnt_q != FULL_CNT) begin
                        cnt_q <= cnt_q + (AW + 1)'(1);
                    end
                    // A final word at the top address is a legal launch
                    if (last_q) begin
                        state_q   <= S_LAUNCH;
                        mem_sel_q <= 1'b0;
                        start_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (mem_lo_q == LAST_ADDR) begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_LAUNCH: begin
                    start_q <= 1'b0;
                    addr_q  <= '0;
                    idx_q   <= 2'd0;
                    last_q  <= 1'b0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (core_done) begin
                        state_q   <= S_LOAD;
                        mem_sel_q <= 1'b1;
                        busy_q    <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                S_ERROR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= S_ERROR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: byte programs in, memory writes
// and start pulses checked against a word-level model.
module tb_program_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [AW-1:0] mem_lo;
    logic [31:0]   mem_in;
    logic          mem_en;
    logic          mem_sel;
    logic          start;
    logic          core_done = 1'b0;
    logic          busy;
    logic [AW:0]   word_count;
    logic          err;

    int  checks = 0;
    int  errors = 0;
    int  exp_starts = 0;
    wr_t exp_wr[$];
    wr_t mon_e;

    program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .mem_lo(mem_lo),
        .mem_in(mem_in),
        .mem_en(mem_en),
        .mem_sel(mem_sel),
        .start(start),
        .core_done(core_done),
        .busy(busy),
        .word_count(word_count),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every start must be expected
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            chk("wr_sel", mem_sel, 1);
            chk("wr_ready", in_ready, 0);
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                         mem_lo, mem_in);
            end else begin
                mon_e = exp_wr.pop_front();
                chk("wr_addr", mem_lo, mon_e.a);
                chk("wr_data", mem_in, mon_e.d);
            end
        end
        if (start === 1'b1) begin
            chk("start_sel", mem_sel, 0);
            chk("start_busy", busy, 1);
            if (exp_starts == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got start=1 expected 0");
            end else begin
                exp_starts--;
            end
        end
    end

    // Reference: program bytes -> zero-padded LE words at 0,1,2,...
    task automatic push_prog(input logic [7:0] q[$], input bit has_last,
                             output int nw);
        logic [31:0] w;
        nw = (q.size() + 3) / 4;
        for (int k = 0; k < nw && k < DEPTH; k++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < q.size()) begin
                    w = w | (32'(q[4 * k + j]) << (8 * j));
                end
            end
            exp_wr.push_back('{a: AW'(k), d: w});
        end
        if (has_last && nw <= DEPTH) exp_starts++;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last,
                             input int gap, output bit ok);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            in_last  = last;
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_reset();
        chk("rst_mem_lo", mem_lo, 0);
        chk("rst_mem_in", mem_in, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_sel", mem_sel, 1);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    // gapmode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
    task automatic run_prog(input logic [7:0] q[$], input int gapmode);
        int nw;
        int gap;
        bit ok;
        push_prog(q, 1'b1, nw);
        for (int i = 0; i < q.size(); i++) begin
            gap = (gapmode == 0) ? 0 :
                  (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
            send_byte(q[i], (i == q.size() - 1), gap, ok);
            chk("accept", ok, 1);
            if (!ok) return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("last_wr_latency", mem_en, 1);
        @(negedge clk);
        chk("launch_start", start, 1);
        chk("launch_sel", mem_sel, 0);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_start", start, 0);
        chk("run_sel", mem_sel, 0);
        chk("run_word_count", word_count, nw);
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            chk("run_in_ready", in_ready, 0);
            chk("run_busy_hold", busy, 1);
        end
        in_valid  = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'($urandom);
        chk("done_busy", busy, 0);
        chk("done_sel", mem_sel, 1);
        chk("done_word_count", word_count, 0);
        chk("done_in_ready", in_ready, 1);
        @(negedge clk);
        core_done = 1'b0;
    endtask

    logic [7:0] q[$];
    bit ok;
    int nw;

    initial begin
        #1 rst = 1'b0;
        #2 chk_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        q = '{8'h13, 8'h00, 8'h50, 8'h00};
        run_prog(q, 0);

        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_prog(q, 1);

        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        run_prog(q, 2);

        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        run_prog(q, 2);

        for (int p = 0; p < 15; p++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, 16)); i++) begin
                q.push_back(8'($urandom));
            end
            run_prog(q, p % 3);
        end

        // Asynchronous reset after two bytes of a word
        send_byte(8'h11, 1'b0, 0, ok);
        send_byte(8'h22, 1'b0, 0, ok);
        #2;
        in_valid = 1'b0;
        rst = 1'b0;
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b1;
        q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_prog(q, 0);

        // Overflow: 17 bytes and no last
        q.delete();
        for (int i = 0; i < 17; i++) q.push_back(8'($urandom));
        push_prog(q, 1'b0, nw);
        for (int i = 0; i < 17; i++) begin
            send_byte(q[i], 1'b0, int'($urandom_range(0, 1)), ok);
            chk("ovf_accept", ok, (i < 16) ? 1 : 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_err", err, 1);
        chk("ovf_in_ready", in_ready, 0);
        chk("ovf_sel", mem_sel, 1);
        chk("ovf_busy", busy, 0);
        chk("ovf_word_count", word_count, DEPTH);
        core_done = 1'b1;
        repeat (5) @(negedge clk);
        core_done = 1'b0;
        chk("ovf_err_sticky", err, 1);
        chk("ovf_ready_low", in_ready, 0);

        #2 rst = 1'b0;
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_starts", exp_starts, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
